op_stack: RTL and testbench

//  LIFO storage for pending operators of the expression evaluator. Sits directly

---
 rtl/op_stack.sv | 100 ++++++++++
 tb/tb_op_stack.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/op_stack.sv
// LIFO operator stack for the expression evaluator; shares the operator bus with the command driver.
// Optional high-water-mark output is enabled by defining OP_STACK_HWM_EN.
`ifndef SC_N
`define SC_N   3
`define SC_NON 3'd0
`define SC_PUS 3'd1
`define SC_POP 3'd2
`define SC_TOP 3'd3
`define SC_CLR 3'd4
`endif
`ifndef CO_N
`define CO_N  4
`define CO_NO 4'h0
`endif

module op_stack #(
  parameter int W  = `CO_N,
  parameter int AW = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [`SC_N-1:0]  cmd,
  inout  wire  [W-1:0]      data,
  output logic              empty,
  output logic              full,
  output logic              err,
`ifdef OP_STACK_HWM_EN
  output logic [AW:0]       hwm,
`endif
  output logic [AW:0]       count
);

  localparam int DEPTH = 2**AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   count_next;
  logic          err_next;
  logic          do_write;
  logic          drive;
  logic [AW-1:0] top_idx;
  logic [W-1:0]  rd_val;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign top_idx = AW'(count - (AW+1)'(1));

  // The top entry sits one below count; an empty stack answers with the no-operator code.
  assign rd_val = empty ? W'(`CO_NO) : mem[top_idx];
  assign drive  = (cmd == `SC_TOP) || (cmd == `SC_POP);
  assign data   = drive ? rd_val : {W{1'bz}};

  always_comb begin
    count_next = count;
    err_next   = err;
    do_write   = 1'b0;
    case (cmd)
      `SC_NON, `SC_TOP: ;
      `SC_PUS: begin
        if (!full) begin
          do_write   = 1'b1;
          count_next = count + (AW+1)'(1);
        end else begin
          err_next = 1'b1;
        end
      end
      `SC_POP: begin
        if (!empty) count_next = count - (AW+1)'(1);
        else        err_next   = 1'b1;
      end
      `SC_CLR: begin
        count_next = '0;
        err_next   = 1'b0;
      end
      default: err_next = 1'b1;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      count <= count_next;
      err   <= err_next;
    end
  end

  // Storage is never reset; only entries below count are meaningful.
  always_ff @(posedge Clock) begin
    if (Reset && do_write) mem[count[AW-1:0]] <= data;
  end

`ifdef OP_STACK_HWM_EN
  always_ff @(posedge Clock) begin
    if (!Reset || cmd == `SC_CLR) hwm <= '0;
    else if (count_next > hwm)    hwm <= count_next;
  end
`endif

endmodule

// File: tb/tb_op_stack.sv
// Self-checking bench for op_stack: directed scenarios with literal expectations plus
// randomized commands checked every cycle against a queue-based LIFO model.
`ifndef SC_N
`define SC_N   3
`define SC_NON 3'd0
`define SC_PUS 3'd1
`define SC_POP 3'd2
`define SC_TOP 3'd3
`define SC_CLR 3'd4
`endif
`ifndef CO_N
`define CO_N  4
`define CO_NO 4'h0
`endif

module tb_op_stack;
  localparam int W     = `CO_N;
  localparam int AW    = 4;
  localparam int DEPTH = 2**AW;

  logic             Clock = 1'b0;
  logic             Reset = 1'b0;
  logic [`SC_N-1:0] cmd   = `SC_NON;
  logic [W-1:0]     tb_val = '0;
  wire  [W-1:0]     data;
  logic             empty, full, err;
  logic [AW:0]      count;
`ifdef OP_STACK_HWM_EN
  logic [AW:0]      hwm;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: a plain queue plus sticky error and peak occupancy.
  logic [W-1:0] q[$];
  bit           m_err = 0;
  int           m_hwm = 0;
  bit           model_ok = 0;

  assign data = (cmd == `SC_PUS) ? tb_val : {W{1'bz}};

  op_stack #(.W(W), .AW(AW)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .cmd(cmd),
    .data(data),
    .empty(empty),
    .full(full),
    .err(err),
`ifdef OP_STACK_HWM_EN
    .hwm(hwm),
`endif
    .count(count)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after the rising edge so they are stable well before the next one.
  task automatic applyStimulus(input logic [`SC_N-1:0] c, input logic [W-1:0] v, input logic rst_n);
    @(posedge Clock);
    #2;
    cmd    = c;
    tb_val = v;
    Reset  = rst_n;
  endtask

  task automatic expectNow(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkOutput(name, act, exp);
  endtask

  // Model update on the same edge the DUT samples.
  always @(posedge Clock) begin
    if (!Reset) begin
      q.delete();
      m_err    = 0;
      m_hwm    = 0;
      model_ok = 1;
    end else if (model_ok) begin
      case (cmd)
        `SC_NON, `SC_TOP: ;
        `SC_PUS: if (q.size() < DEPTH) q.push_back(tb_val); else m_err = 1;
        `SC_POP: if (q.size() > 0) void'(q.pop_back()); else m_err = 1;
        `SC_CLR: begin q.delete(); m_err = 0; m_hwm = 0; end
        default: m_err = 1;
      endcase
      if (q.size() > m_hwm) m_hwm = q.size();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge Clock) begin
    if (model_ok) begin
      checkOutput("count", 32'(count), 32'(q.size()));
      checkOutput("empty", 32'(empty), 32'(q.size() == 0));
      checkOutput("full",  32'(full),  32'(q.size() == DEPTH));
      checkOutput("err",   32'(err),   32'(m_err));
`ifdef OP_STACK_HWM_EN
      checkOutput("hwm",   32'(hwm),   32'(m_hwm));
`endif
      if (cmd == `SC_TOP || cmd == `SC_POP)
        checkOutput("bus", 32'(data), (q.size() > 0) ? 32'(q[$]) : 32'(`CO_NO));
      checkOutput("bus_contention", 32'($isunknown(data)), 32'(0));
    end
  end

  initial begin
    logic [W-1:0] v;
    int r;

    // Reset state
    applyStimulus(`SC_NON, '0, 1'b0);
    applyStimulus(`SC_NON, '0, 1'b1);
    @(negedge Clock); #1;
    expectNow("rst_empty", 32'(empty), 1);
    expectNow("rst_full",  32'(full),  0);
    expectNow("rst_err",   32'(err),   0);
    expectNow("rst_count", 32'(count), 0);

    // Push 3,5,7 then read back in LIFO order
    applyStimulus(`SC_PUS, 4'd3, 1'b1);
    applyStimulus(`SC_PUS, 4'd5, 1'b1);
    applyStimulus(`SC_PUS, 4'd7, 1'b1);
    applyStimulus(`SC_TOP, '0, 1'b1);
    @(negedge Clock); #1;
    expectNow("top7", 32'(data), 7);
    expectNow("top_count3", 32'(count), 3);
    applyStimulus(`SC_POP, '0, 1'b1); @(negedge Clock); #1; expectNow("pop7", 32'(data), 7);
    applyStimulus(`SC_POP, '0, 1'b1); @(negedge Clock); #1; expectNow("pop5", 32'(data), 5);
    applyStimulus(`SC_POP, '0, 1'b1); @(negedge Clock); #1; expectNow("pop3", 32'(data), 3);
    applyStimulus(`SC_NON, '0, 1'b1); @(negedge Clock); #1;
    expectNow("empty_after_pops", 32'(empty), 1);

    // Fill to DEPTH, then overflow must not overwrite the top entry
    for (int i = 0; i < DEPTH; i++) begin
      v = W'(i) ^ W'(5);
      applyStimulus(`SC_PUS, v, 1'b1);
    end
    applyStimulus(`SC_NON, '0, 1'b1); @(negedge Clock); #1;
    expectNow("full_flag", 32'(full), 1);
    expectNow("full_count", 32'(count), DEPTH);
    applyStimulus(`SC_PUS, 4'd3, 1'b1);
    applyStimulus(`SC_TOP, '0, 1'b1); @(negedge Clock); #1;
    expectNow("ovf_count", 32'(count), DEPTH);
    expectNow("ovf_err", 32'(err), 1);
    expectNow("ovf_top_kept", 32'(data), 10);

    // Underflow after clearing
    applyStimulus(`SC_CLR, '0, 1'b1);
    applyStimulus(`SC_POP, '0, 1'b1); @(negedge Clock); #1;
    expectNow("underflow_bus", 32'(data), 32'(`CO_NO));
    applyStimulus(`SC_NON, '0, 1'b1); @(negedge Clock); #1;
    expectNow("underflow_err", 32'(err), 1);
    expectNow("underflow_count", 32'(count), 0);
    applyStimulus(`SC_CLR, '0, 1'b1);
    applyStimulus(`SC_NON, '0, 1'b1); @(negedge Clock); #1;
    expectNow("clr_err", 32'(err), 0);
    expectNow("clr_empty", 32'(empty), 1);

    // Reset beats a simultaneous push
    applyStimulus(`SC_PUS, 4'd1, 1'b1);
    applyStimulus(`SC_PUS, 4'd2, 1'b1);
    applyStimulus(`SC_PUS, 4'd9, 1'b0);
    applyStimulus(`SC_NON, '0, 1'b1); @(negedge Clock); #1;
    expectNow("rst_push_count", 32'(count), 0);
    expectNow("rst_push_err", 32'(err), 0);

`ifdef OP_STACK_HWM_EN
    for (int i = 0; i < 5; i++) applyStimulus(`SC_PUS, W'(i + 1), 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(`SC_POP, '0, 1'b1);
    applyStimulus(`SC_PUS, 4'd6, 1'b1);
    applyStimulus(`SC_NON, '0, 1'b1); @(negedge Clock); #1;
    expectNow("hwm5", 32'(hwm), 5);
    expectNow("hwm_count3", 32'(count), 3);
    applyStimulus(`SC_CLR, '0, 1'b1);
    applyStimulus(`SC_NON, '0, 1'b1); @(negedge Clock); #1;
    expectNow("hwm_clr", 32'(hwm), 0);
`endif

    // Randomized traffic, push-biased so full and overflow are visited
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      v = W'($urandom);
      if      (r < 45) applyStimulus(`SC_PUS, v, 1'b1);
      else if (r < 72) applyStimulus(`SC_POP, v, 1'b1);
      else if (r < 82) applyStimulus(`SC_TOP, v, 1'b1);
      else if (r < 88) applyStimulus(`SC_NON, v, 1'b1);
      else if (r < 92) applyStimulus(`SC_CLR, v, 1'b1);
      else if (r < 97) applyStimulus(3'(5 + $urandom_range(0, 2)), v, 1'b1);
      else             applyStimulus(`SC_PUS, v, 1'b0);
    end
    applyStimulus(`SC_NON, '0, 1'b1);
    @(negedge Clock); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
